// File: rtl/vstream_if.sv
// ---------------------------------------------------------------------------
// vstream_if -- video timing/pixel bus produced by vstream_gen.
//
//   do_o  [PIXEL_WIDTH]  pixel data, meaningful only while de_o=1 (0 otherwise)
//   de_o                 pixel valid strobe
//   hs_o                 horizontal blanking (also high during vertical blanking)
//   vs_o                 vertical blanking (high outside the active frame)
//
// master: the generator (drives everything); slave: a video sink.
// ---------------------------------------------------------------------------
interface vstream_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (output do_o, de_o, hs_o, vs_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/vstream_gen.sv
// ---------------------------------------------------------------------------
// vstream_gen -- test-pattern video stream generator.
//
// Produces frames of height x width pixels framed by vertical blanking
// (V_BLANK cycles before each frame) and horizontal blanking (H_BLANK cycles
// between lines). Each pixel occupies max(DE_PERIOD,1) cycles, with de_o in
// the last cycle of its slot. Frame geometry and pattern are latched only at
// frame start, so requests changing mid-frame never disturb a running frame.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         run request, sampled only when a new frame could start
//   width_i    active pixels per line (clamped to LINE_SIZE_MAX)
//   height_i   active lines per frame
//   pattern_i  0: x, 1: y, 2: x+y+frame count, 3: PULSE_STEP dot grid
//   vid        vstream_if master: do_o / de_o / hs_o / vs_o
//   busy_o     high whenever not idle
//   fr_cnt_o   completed-frame counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module vstream_gen #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int LINE_SIZE_MAX = 4096,
    parameter int DE_PERIOD     = 0,
    parameter int H_BLANK       = 16,
    parameter int V_BLANK       = 64,
    parameter int PULSE_STEP    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] width_i,
    input  logic [15:0] height_i,
    input  logic [1:0]  pattern_i,
    vstream_if.master   vid,
    output logic        busy_o,
    output logic [15:0] fr_cnt_o
);

    localparam int          PER      = (DE_PERIOD <= 1) ? 1 : DE_PERIOD;
    localparam logic [15:0] PER_LAST = 16'(PER - 1);
    localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] LMAX     = 16'(LINE_SIZE_MAX);
    localparam int          PS_W     = $clog2(PULSE_STEP);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PULSE_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VBLANK,
        S_ACTIVE,
        S_HBLANK
    } state_t;

    // Saturate the requested line width to the supported maximum.
    function automatic logic [15:0] sat_width(input logic [15:0] w);
        return (w > LMAX) ? LMAX : w;
    endfunction

    // Pixel value for position (x,y); xz/yz flag the PULSE_STEP grid lines,
    // tracked by wrapping counters so no divider is needed.
    function automatic logic [PIXEL_WIDTH-1:0] pix_value(
        input logic [1:0]  pat,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] fr,
        input logic        xz,
        input logic        yz
    );
        logic [15:0]            sum;
        logic [PIXEL_WIDTH-1:0] res;
        sum = x + y + fr;
        case (pat)
            2'd0:    res = PIXEL_WIDTH'(x);
            2'd1:    res = PIXEL_WIDTH'(y);
            2'd2:    res = PIXEL_WIDTH'(sum);
            default: res = (xz && yz) ? '1 : '0;
        endcase
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            x_q, x_d;
    logic [15:0]            y_q, y_d;
    logic [PS_W-1:0]        xm_q, xm_d;
    logic [PS_W-1:0]        ym_q, ym_d;
    logic [15:0]            w_q, w_d;
    logic [15:0]            h_q, h_d;
    logic [1:0]             pat_q, pat_d;
    logic [15:0]            fr_q, fr_d;
    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   busy_q, busy_d;
    logic                   start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xm_q    <= '0;
            ym_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            pat_q   <= '0;
            fr_q    <= '0;
            do_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            w_q     <= w_d;
            h_q     <= h_d;
            pat_q   <= pat_d;
            fr_q    <= fr_d;
            do_q    <= do_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
        end
    end

    // cnt_q counts blanking cycles in VBLANK/HBLANK and the cycle within the
    // current pixel slot in ACTIVE. Registered outputs are derived from the
    // next state so they line up with state_q in the cycle they describe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        xm_d     = xm_q;
        ym_d     = ym_q;
        w_d      = w_q;
        h_d      = h_q;
        pat_d    = pat_q;
        fr_d     = fr_q;
        start_ok = en && (width_i != 16'd0) && (height_i != 16'd0);

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    w_d     = sat_width(width_i);
                    h_d     = height_i;
                    pat_d   = pattern_i;
                    cnt_d   = '0;
                    state_d = S_VBLANK;
                end
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    xm_d    = '0;
                    ym_d    = '0;
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (x_q == w_q - 16'd1) begin
                        if (y_q == h_q - 16'd1) begin
                            fr_d = fr_q + 16'd1;
                            if (start_ok) begin
                                w_d     = sat_width(width_i);
                                h_d     = height_i;
                                pat_d   = pattern_i;
                                state_d = S_VBLANK;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            state_d = S_HBLANK;
                        end
                    end else begin
                        x_d  = x_q + 16'd1;
                        xm_d = (xm_q == PS_LAST) ? '0 : xm_q + PS_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d   = '0;
                    x_d     = '0;
                    xm_d    = '0;
                    y_d     = y_q + 16'd1;
                    ym_d    = (ym_q == PS_LAST) ? '0 : ym_q + PS_W'(1);
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        de_d   = (state_d == S_ACTIVE) && (cnt_d == PER_LAST);
        do_d   = de_d ? pix_value(pat_d, x_d, y_d, fr_q, xm_d == '0, ym_d == '0) : '0;
        hs_d   = (state_d != S_ACTIVE);
        vs_d   = (state_d == S_IDLE) || (state_d == S_VBLANK);
        busy_d = (state_d != S_IDLE);
    end

    assign vid.do_o = do_q;
    assign vid.de_o = de_q;
    assign vid.hs_o = hs_q;
    assign vid.vs_o = vs_q;
    assign busy_o   = busy_q;
    assign fr_cnt_o = fr_q;

endmodule
